process_scheduler: RTL and testbench

Hardware round-robin process scheduler for the multiprogrammed CPU. It keeps a small process table (slot state plus saved PC per process) and counts the quantum in retired instructions. On quantum expiry, process end or an IO request it picks the next ready process and asks the CPU to switch context through a req/ack handshake. It sits beside the PC-update logic and replaces the software scheduler's bookkeeping; the CPU still performs the actual PC load.

---
 rtl/sched_pkg.sv | 22 ++
 rtl/process_scheduler_if.sv | 27 ++
 rtl/sched_slot_scan.sv | 39 +++
 rtl/process_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_process_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// Shared types and default sizing for the round-robin process scheduler.
package sched_pkg;

    typedef enum logic [1:0] {
        FREE,
        READY,
        RUNNING,
        BLOCKED
    } slot_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SELECT,
        SWITCH
    } sched_state_t;

    localparam int DEFAULT_NPROC   = 8;
    localparam int DEFAULT_QUANTUM = 16;
    localparam int DEFAULT_PC_W    = 32;

endpackage

// File: rtl/process_scheduler_if.sv
// Context-switch handshake between the scheduler (master) and the CPU PC-update logic (slave).
interface process_scheduler_if #(
    parameter int NPROC = sched_pkg::DEFAULT_NPROC,
    parameter int PC_W  = sched_pkg::DEFAULT_PC_W
);
    localparam int PID_W = $clog2(NPROC);

    logic             switch_req;
    logic             switch_ack;
    logic [PID_W-1:0] next_pid;
    logic [PC_W-1:0]  next_pc;

    modport master (
        output switch_req,
        output next_pid,
        output next_pc,
        input  switch_ack
    );

    modport slave (
        input  switch_req,
        input  next_pid,
        input  next_pc,
        output switch_ack
    );

endinterface

// File: rtl/sched_slot_scan.sv
// Rotating scan pointer for SELECT: examines one slot per cycle and flags the first READY one,
// or exhaustion once all NPROC slots have been examined.
module sched_slot_scan import sched_pkg::*; #(
    parameter int NPROC = DEFAULT_NPROC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [$clog2(NPROC)-1:0] startPid,
    input  logic                     active,
    input  logic [NPROC-1:0]         readyMask,
    output logic                     found,
    output logic [$clog2(NPROC)-1:0] pid,
    output logic                     exhausted
);

    localparam int PID_W = $clog2(NPROC);

    logic [PID_W-1:0] ptr;
    logic [PID_W-1:0] examined;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            examined <= '0;
        end else if (start) begin
            ptr      <= startPid;
            examined <= '0;
        end else if (active) begin
            ptr      <= ptr + 1'b1;
            examined <= examined + 1'b1;
        end
    end

    assign pid       = ptr;
    assign found     = active && readyMask[ptr];
    assign exhausted = active && !found && (examined == PID_W'(NPROC - 1));

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: slot table, instruction-count quantum and context-switch handshake.
// SCHED_IO_BLOCK_EN: when defined, io_req blocks the process until io_done; otherwise io_req is a yield.
module process_scheduler import sched_pkg::*; #(
    parameter int NPROC   = DEFAULT_NPROC,
    parameter int QUANTUM = DEFAULT_QUANTUM,
    parameter int PC_W    = DEFAULT_PC_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     instr_retire,
    input  logic [PC_W-1:0]          resume_pc,
    input  logic                     proc_create,
    input  logic [PC_W-1:0]          create_pc,
    input  logic                     proc_end,
    input  logic                     io_req,
    input  logic                     io_done,
    input  logic [$clog2(NPROC)-1:0] io_done_id,
    process_scheduler_if.master      sw,
    output logic [$clog2(NPROC)-1:0] cur_pid,
    output logic                     idle,
    output logic                     create_full,
    output logic [$clog2(NPROC):0]   num_procs
);

    localparam int PID_W = $clog2(NPROC);
    localparam int QW    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

`ifdef SCHED_IO_BLOCK_EN
    localparam slot_state_t IO_SLOT_STATE = BLOCKED;
`else
    localparam slot_state_t IO_SLOT_STATE = READY;
    logic unusedIo;
    assign unusedIo = io_done ^ (^io_done_id);
`endif

    slot_state_t      slotState [NPROC];
    logic [PC_W-1:0]  savedPc   [NPROC];

    sched_state_t     state;
    logic [PID_W-1:0] curPid;
    logic [PID_W-1:0] nextPid;
    logic [PC_W-1:0]  nextPc;
    logic             switchReq;
    logic             idleReg;
    logic [QW-1:0]    quantumCnt;

    logic [NPROC-1:0] readyMask;
    logic             createHit;
    logic [PID_W-1:0] createSlot;
    logic [PID_W:0]   procCount;

    always_comb begin
        readyMask  = '0;
        createHit  = 1'b0;
        createSlot = '0;
        procCount  = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            readyMask[i] = (slotState[i] == READY);
            if (slotState[i] == FREE) begin
                createHit  = 1'b1;
                createSlot = PID_W'(i);
            end else begin
                procCount = procCount + 1'b1;
            end
        end
    end

    // RUN events are mutually exclusive by priority: end > io > expiry.
    logic runActive, endEv, ioEv, expEv, runToSelect, idleToSelect, ackEv;

    assign runActive    = (state == RUN) && enable;
    assign endEv        = runActive && proc_end;
    assign ioEv         = runActive && !proc_end && io_req;
    assign expEv        = runActive && !proc_end && !io_req && instr_retire
                          && (quantumCnt == QW'(QUANTUM - 1));
    assign runToSelect  = endEv || ioEv || expEv;
    assign idleToSelect = (state == IDLE) && enable && (|readyMask);
    assign ackEv        = (state == SWITCH) && switchReq && sw.switch_ack;

    logic             scanFound, scanExhausted;
    logic [PID_W-1:0] scanPid;
    logic [PID_W-1:0] scanStartPid;

    // Coming out of IDLE nothing is running, so the scan starts at cur_pid itself.
    assign scanStartPid = idleToSelect ? curPid : curPid + 1'b1;

    sched_slot_scan #(.NPROC(NPROC)) u_scan (
        .clock     (clock),
        .reset     (reset),
        .start     (runToSelect || idleToSelect),
        .startPid  (scanStartPid),
        .active    (state == SELECT),
        .readyMask (readyMask),
        .found     (scanFound),
        .pid       (scanPid),
        .exhausted (scanExhausted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NPROC; i++) begin
                slotState[i] <= FREE;
                savedPc[i]   <= '0;
            end
        end else begin
            if (proc_create && createHit) begin
                slotState[createSlot] <= READY;
                savedPc[createSlot]   <= create_pc;
            end
`ifdef SCHED_IO_BLOCK_EN
            if (io_done && (slotState[io_done_id] == BLOCKED)) begin
                slotState[io_done_id] <= READY;
            end
`endif
            if (endEv) begin
                slotState[curPid] <= FREE;
            end else if (ioEv) begin
                slotState[curPid] <= IO_SLOT_STATE;
                savedPc[curPid]   <= resume_pc;
            end else if (expEv) begin
                slotState[curPid] <= READY;
                savedPc[curPid]   <= resume_pc;
            end
            if (ackEv) begin
                slotState[nextPid] <= RUNNING;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            curPid     <= '0;
            nextPid    <= '0;
            nextPc     <= '0;
            switchReq  <= 1'b0;
            idleReg    <= 1'b1;
            quantumCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (idleToSelect) begin
                        state   <= SELECT;
                        idleReg <= 1'b0;
                    end
                end
                RUN: begin
                    if (runToSelect) begin
                        state <= SELECT;
                    end else if (runActive && instr_retire) begin
                        quantumCnt <= quantumCnt + 1'b1;
                    end
                end
                SELECT: begin
                    if (scanFound) begin
                        nextPid   <= scanPid;
                        nextPc    <= savedPc[scanPid];
                        switchReq <= 1'b1;
                        state     <= SWITCH;
                    end else if (scanExhausted) begin
                        state   <= IDLE;
                        idleReg <= 1'b1;
                    end
                end
                SWITCH: begin
                    if (ackEv) begin
                        curPid     <= nextPid;
                        quantumCnt <= '0;
                        switchReq  <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sw.switch_req = switchReq;
    assign sw.next_pid   = nextPid;
    assign sw.next_pc    = nextPc;
    assign cur_pid       = curPid;
    assign idle          = idleReg;
    assign create_full   = !createHit;
    assign num_procs     = procCount;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed vector table, corner-case sequences, and random traffic
// against a slot-table reference model.
module tb_process_scheduler;

    localparam int NP    = 8;
    localparam int QUANT = 4;
`ifdef SCHED_IO_BLOCK_EN
    localparam bit IOBLK = 1'b1;
`else
    localparam bit IOBLK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, enable, instr_retire, proc_create, proc_end, io_req, io_done;
    logic [31:0] resume_pc, create_pc;
    logic [2:0]  io_done_id;
    logic [2:0]  cur_pid;
    logic        idle, create_full;
    logic [3:0]  num_procs;

    process_scheduler_if #(.NPROC(NP), .PC_W(32)) swIf ();

    process_scheduler #(.NPROC(NP), .QUANTUM(QUANT), .PC_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .instr_retire (instr_retire),
        .resume_pc    (resume_pc),
        .proc_create  (proc_create),
        .create_pc    (create_pc),
        .proc_end     (proc_end),
        .io_req       (io_req),
        .io_done      (io_done),
        .io_done_id   (io_done_id),
        .sw           (swIf),
        .cur_pid      (cur_pid),
        .idle         (idle),
        .create_full  (create_full),
        .num_procs    (num_procs)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nFail   = 0;
    bit randMode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: slot table plus a phase and a scan position.
    localparam int M_FREE = 0, M_READY = 1, M_RUNNING = 2, M_BLOCKED = 3;
    localparam int P_IDLE = 0, P_RUN = 1, P_SEL = 2, P_SW = 3;

    int          mSlot [NP];
    logic [31:0] mPc   [NP];
    int          mPhase, mCur, mNextPid, mScanFrom, mScanK, mQ;
    logic [31:0] mNextPc;
    bit          mReq, mIdle;

    task automatic modelStep();
        int          nSlot [NP];
        logic [31:0] nPc   [NP];
        int          freeIdx, p;
        bit          anyReady;
        if (reset) begin
            for (int i = 0; i < NP; i++) begin
                mSlot[i] = M_FREE;
                mPc[i]   = 0;
            end
            mPhase = P_IDLE; mCur = 0; mNextPid = 0; mNextPc = 0;
            mScanFrom = 0; mScanK = 0; mQ = 0; mReq = 0; mIdle = 1;
            return;
        end
        nSlot = mSlot;
        nPc   = mPc;
        freeIdx  = -1;
        anyReady = 0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (mSlot[i] == M_FREE) freeIdx = i;
            if (mSlot[i] == M_READY) anyReady = 1;
        end
        if (proc_create && freeIdx >= 0) begin
            nSlot[freeIdx] = M_READY;
            nPc[freeIdx]   = create_pc;
        end
        if (IOBLK && io_done && mSlot[io_done_id] == M_BLOCKED) nSlot[io_done_id] = M_READY;
        case (mPhase)
            P_IDLE: if (enable && anyReady) begin
                mPhase = P_SEL; mScanFrom = mCur; mScanK = 0; mIdle = 0;
            end
            P_RUN: if (enable) begin
                if (proc_end) begin
                    nSlot[mCur] = M_FREE;
                    mPhase = P_SEL; mScanFrom = (mCur + 1) % NP; mScanK = 0;
                end else if (io_req) begin
                    nSlot[mCur] = IOBLK ? M_BLOCKED : M_READY;
                    nPc[mCur]   = resume_pc;
                    mPhase = P_SEL; mScanFrom = (mCur + 1) % NP; mScanK = 0;
                end else if (instr_retire) begin
                    if (mQ == QUANT - 1) begin
                        nSlot[mCur] = M_READY;
                        nPc[mCur]   = resume_pc;
                        mPhase = P_SEL; mScanFrom = (mCur + 1) % NP; mScanK = 0;
                    end else begin
                        mQ++;
                    end
                end
            end
            P_SEL: begin
                p = (mScanFrom + mScanK) % NP;
                if (mSlot[p] == M_READY) begin
                    mNextPid = p; mNextPc = mPc[p]; mReq = 1; mPhase = P_SW;
                end else if (mScanK == NP - 1) begin
                    mPhase = P_IDLE; mIdle = 1;
                end else begin
                    mScanK++;
                end
            end
            default: if (swIf.switch_ack) begin
                nSlot[mNextPid] = M_RUNNING;
                mCur = mNextPid; mQ = 0; mReq = 0; mPhase = P_RUN;
            end
        endcase
        mSlot = nSlot;
        mPc   = nPc;
    endtask

    task automatic compareModel();
        int num = 0;
        for (int i = 0; i < NP; i++) if (mSlot[i] != M_FREE) num++;
        check("rnd switch_req", 32'(swIf.switch_req), 32'(mReq));
        check("rnd next_pid", 32'(swIf.next_pid), 32'(mNextPid));
        check("rnd next_pc", swIf.next_pc, mNextPc);
        check("rnd cur_pid", 32'(cur_pid), 32'(mCur));
        check("rnd idle", 32'(idle), 32'(mIdle));
        check("rnd create_full", 32'(create_full), 32'(num == NP));
        check("rnd num_procs", 32'(num_procs), 32'(num));
    endtask

    task automatic tick();
        modelStep();
        @(posedge clock);
        #1;
        if (randMode) compareModel();
    endtask

    task automatic clr();
        reset = 0; instr_retire = 0; proc_create = 0; proc_end = 0; io_req = 0; io_done = 0;
        swIf.switch_ack = 0; resume_pc = 0; create_pc = 0; io_done_id = 0;
    endtask

    task automatic doReset();
        clr();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic waitReq(input string name, input int maxCyc, output int cyc);
        cyc = 0;
        while (!swIf.switch_req && cyc < maxCyc) begin
            tick();
            cyc++;
        end
        check({name, " switch_req raised"}, 32'(swIf.switch_req), 1);
    endtask

    task automatic ackSwitch();
        swIf.switch_ack = 1;
        tick();
        swIf.switch_ack = 0;
    endtask

    typedef struct {
        logic        rst, en, cr, ret, ack;
        logic [31:0] crPc, rpc;
        logic        expReq;
        int          expPid;
        logic [31:0] expPc;
        int          expCur;
        logic        expIdle, expFull;
        int          expNum;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rst, en, cr, input logic [31:0] crPc, input logic ret,
                          input logic [31:0] rpc, input logic ack, input logic eReq, input int ePid,
                          input logic [31:0] ePc, input int eCur, input logic eIdle, input int eNum);
        vec_t v;
        v.rst = rst; v.en = en; v.cr = cr; v.crPc = crPc; v.ret = ret; v.rpc = rpc; v.ack = ack;
        v.expReq = eReq; v.expPid = ePid; v.expPc = ePc; v.expCur = eCur; v.expIdle = eIdle;
        v.expNum = eNum; v.expFull = (eNum == NP);
        vecs.push_back(v);
    endtask

    initial begin
        int c;
        bit sawIdle, ioSent;

        clr();
        enable = 0;
        //     rst en cr crPc   ret rpc    ack  req pid pc     cur idle num
        addVec(1,  0, 0, 0,     0,  0,     0,   0,  0,  0,     0,  1,   0);
        addVec(0,  0, 1, 'h10,  0,  0,     0,   0,  0,  0,     0,  1,   1);
        addVec(0,  0, 1, 'h20,  0,  0,     0,   0,  0,  0,     0,  1,   2);
        addVec(0,  0, 1, 'h30,  0,  0,     0,   0,  0,  0,     0,  1,   3);
        addVec(0,  1, 0, 0,     0,  0,     0,   0,  0,  0,     0,  0,   3);
        addVec(0,  1, 0, 0,     0,  0,     0,   1,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     0,  0,     1,   0,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     1,  'h14,  1,   0,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     1,  'h14,  0,   0,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     1,  'h14,  0,   0,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     1,  'h14,  0,   0,  0,  'h10,  0,  0,   3);
        addVec(0,  1, 0, 0,     0,  0,     0,   1,  1,  'h20,  0,  0,   3);
        addVec(0,  1, 0, 0,     0,  0,     1,   0,  1,  'h20,  1,  0,   3);
        addVec(0,  1, 1, 'h99,  0,  0,     0,   0,  1,  'h20,  1,  0,   4);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; enable = vecs[i].en; proc_create = vecs[i].cr;
            create_pc = vecs[i].crPc; instr_retire = vecs[i].ret; resume_pc = vecs[i].rpc;
            swIf.switch_ack = vecs[i].ack;
            tick();
            check($sformatf("vec%0d switch_req", i), 32'(swIf.switch_req), 32'(vecs[i].expReq));
            check($sformatf("vec%0d next_pid", i), 32'(swIf.next_pid), 32'(vecs[i].expPid));
            check($sformatf("vec%0d next_pc", i), swIf.next_pc, vecs[i].expPc);
            check($sformatf("vec%0d cur_pid", i), 32'(cur_pid), 32'(vecs[i].expCur));
            check($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].expIdle));
            check($sformatf("vec%0d num_procs", i), 32'(num_procs), 32'(vecs[i].expNum));
            check($sformatf("vec%0d create_full", i), 32'(create_full), 32'(vecs[i].expFull));
        end

        // Lone process: expiry re-selects it after a full NPROC-slot scan.
        doReset();
        enable = 1;
        proc_create = 1; create_pc = 'h40;
        tick();
        clr();
        waitReq("lone start", 10, c);
        check("lone start latency", c, 2);
        check("lone start pid", 32'(swIf.next_pid), 0);
        check("lone start pc", swIf.next_pc, 'h40);
        ackSwitch();
        instr_retire = 1; resume_pc = 'h44;
        repeat (QUANT) tick();
        clr();
        waitReq("lone expiry", 20, c);
        check("lone reselect latency", c, NP);
        check("lone reselect pid", 32'(swIf.next_pid), 0);
        check("lone reselect pc", swIf.next_pc, 'h44);
        ackSwitch();

        // io_req on the only process: blocks into IDLE until io_done, or yields when blocking is off.
        io_req = 1; resume_pc = 'h50;
        tick();
        clr();
        sawIdle = 0; ioSent = 0; c = 0;
        while (!swIf.switch_req && c < 30) begin
            if (idle) sawIdle = 1;
            if (IOBLK && sawIdle && !ioSent) begin
                io_done = 1; io_done_id = 0; ioSent = 1;
            end
            tick();
            io_done = 0;
            c++;
        end
        check("io switch_req raised", 32'(swIf.switch_req), 1);
        check("io idle phase", 32'(sawIdle), 32'(IOBLK));
        check("io next_pid", 32'(swIf.next_pid), 0);
        check("io next_pc", swIf.next_pc, 'h50);
        ackSwitch();

        // proc_end with io_req in the same cycle: the slot is freed, never blocked.
        proc_create = 1; create_pc = 'h60;
        tick();
        clr();
        check("end+io pre num_procs", 32'(num_procs), 2);
        proc_end = 1; io_req = 1; resume_pc = 'h66;
        tick();
        clr();
        check("end+io num_procs", 32'(num_procs), 1);
        waitReq("end+io", 10, c);
        check("end+io next_pid", 32'(swIf.next_pid), 1);
        check("end+io next_pc", swIf.next_pc, 'h60);
        ackSwitch();
        check("end+io cur_pid", 32'(cur_pid), 1);

        // Fill the table, overflow create, then reset in the middle of SWITCH.
        doReset();
        enable = 0;
        for (int i = 0; i < NP; i++) begin
            proc_create = 1; create_pc = 32'h100 + 32'(i);
            tick();
        end
        clr();
        check("full create_full", 32'(create_full), 1);
        check("full num_procs", 32'(num_procs), NP);
        proc_create = 1; create_pc = 'h999;
        tick();
        clr();
        check("overflow num_procs", 32'(num_procs), NP);
        enable = 1;
        waitReq("full", 10, c);
        check("full next_pc", swIf.next_pc, 'h100);
        reset = 1;
        tick();
        reset = 0;
        check("rst switch_req", 32'(swIf.switch_req), 0);
        check("rst idle", 32'(idle), 1);
        check("rst num_procs", 32'(num_procs), 0);
        check("rst create_full", 32'(create_full), 0);
        check("rst next_pc", swIf.next_pc, 0);
        check("rst cur_pid", 32'(cur_pid), 0);

        // Random traffic against the model.
        doReset();
        randMode = 1;
        for (int n = 0; n < 4000; n++) begin
            enable          = ($urandom_range(0, 9) != 0);
            reset           = ($urandom_range(0, 499) == 0);
            proc_create     = ($urandom_range(0, 7) == 0);
            create_pc       = $urandom;
            instr_retire    = $urandom_range(0, 1);
            resume_pc       = $urandom;
            proc_end        = ($urandom_range(0, 29) == 0);
            io_req          = ($urandom_range(0, 14) == 0);
            io_done         = ($urandom_range(0, 5) == 0);
            io_done_id      = 3'($urandom_range(0, NP - 1));
            swIf.switch_ack = $urandom_range(0, 1);
            tick();
        end
        randMode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
